// File: rtl/alu_share_arb.sv
// Shares one combinational 32-bit ALU between a pipeline EX port (0) and an auxiliary port (1).
// The optional per-port statistics are built when ALU_SHARE_ARB_STAT_EN is defined.
module alu_share_arb #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              freeze,
  input  logic              req0,
  input  logic [31:0]       a0,
  input  logic [31:0]       b0,
  input  logic [3:0]        aluc0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [31:0]       a1,
  input  logic [31:0]       b1,
  input  logic [3:0]        aluc1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_aluc,
  input  logic [31:0]       alu_s,
  output logic [31:0]       res,
`ifdef ALU_SHARE_ARB_STAT_EN
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  output logic [WAIT_W-1:0] max_wait_seen,
`endif
  output logic              starve
);

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  // Handshake: req_i is a valid that the requester holds, with its operands,
  // until gnt_i (the ready) is seen high in the same cycle; req_i && gnt_i is
  // the transfer, and new operands may follow in the very next cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !freeze) begin
      gnt1 = req1 && (!req0 || starve);
      gnt0 = req0 && !gnt1;
    end
  end

  always_comb begin
    alu_a    = a0;
    alu_b    = b0;
    alu_aluc = aluc0;
    if (gnt1) begin
      alu_a    = a1;
      alu_b    = b1;
      alu_aluc = aluc1;
    end
  end

  // Aging: count denied port-1 cycles, saturating so starve stays up until served.
  always_comb begin
    wait_nxt = wait_cnt;
    if (req1 && !gnt1) begin
      if (wait_cnt != MAX_W) wait_nxt = wait_cnt + 1'b1;
    end else begin
      wait_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res      <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (!freeze) begin
      if (gnt0 || gnt1) res <= alu_s;
      rvalid0  <= gnt0;
      rvalid1  <= gnt1;
      wait_cnt <= wait_nxt;
      starve   <= (wait_nxt == MAX_W);
    end
  end

`ifdef ALU_SHARE_ARB_STAT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt0          <= '0;
      cnt1          <= '0;
      max_wait_seen <= '0;
    end else if (!freeze) begin
      if (gnt0) cnt0 <= cnt0 + 16'd1;
      if (gnt1) cnt1 <= cnt1 + 16'd1;
      if (wait_nxt > max_wait_seen) max_wait_seen <= wait_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small ALU model on the shared ALU lines.
module tb_alu_share_arb;

  logic        clock = 1'b0;
  logic        reset, freeze;
  logic        req0, req1, gnt0, gnt1, rvalid0, rvalid1, starve;
  logic [31:0] a0, b0, a1, b1, alu_a, alu_b, alu_s, res;
  logic [3:0]  aluc0, aluc1, alu_aluc;
`ifdef ALU_SHARE_ARB_STAT_EN
  logic [15:0] cnt0, cnt1;
  logic [3:0]  max_wait_seen;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  alu_share_arb #(.MAX_WAIT(4), .WAIT_W(4)) dut (
    .clock(clock), .reset(reset), .freeze(freeze),
    .req0(req0), .a0(a0), .b0(b0), .aluc0(aluc0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .a1(a1), .b1(b1), .aluc1(aluc1), .gnt1(gnt1), .rvalid1(rvalid1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s),
    .res(res),
`ifdef ALU_SHARE_ARB_STAT_EN
    .cnt0(cnt0), .cnt1(cnt1), .max_wait_seen(max_wait_seen),
`endif
    .starve(starve)
  );

  // Shared ALU stand-in: ADD, SUB, OR, bit-difference count; AND otherwise.
  always_comb begin
    case (alu_aluc)
      4'b0000: alu_s = alu_a + alu_b;
      4'b0100: alu_s = alu_a - alu_b;
      4'b0101: alu_s = alu_a | alu_b;
      4'b1110: alu_s = 32'($countones(alu_a ^ alu_b));
      default: alu_s = alu_a & alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [9:0] g1_pat;

  initial begin
    reset = 1'b1; freeze = 1'b0;
    req0 = 1'b0; a0 = '0; b0 = '0; aluc0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0; aluc1 = '0;
    g1_pat = 10'b10_0001_0000;

    // Reset state; grants stay low while reset is high even with requests.
    tick(); tick();
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_starve", 32'(starve), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    reset = 1'b0;

    // Port 0 only: 5 + 3.
    tick();
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; aluc0 = 4'b0000;
    #1;
    check("p0_gnt0", 32'(gnt0), 32'd1);
    check("p0_gnt1", 32'(gnt1), 32'd0);
    check("p0_alu_a", alu_a, 32'd5);
    tick();
    check("p0_rvalid0", 32'(rvalid0), 32'd1);
    check("p0_rvalid1", 32'(rvalid1), 32'd0);
    check("p0_res", res, 32'd8);
    req0 = 1'b0;
    tick();
    check("p0_idle_rvalid0", 32'(rvalid0), 32'd0);
    check("p0_idle_res", res, 32'd8);

    // Port 1 only, back-to-back OR then SUB.
    req1 = 1'b1; a1 = 32'hF0; b1 = 32'h0F; aluc1 = 4'b0101;
    #1;
    check("p1a_gnt1", 32'(gnt1), 32'd1);
    check("p1a_alu_aluc", 32'(alu_aluc), 32'd5);
    tick();
    check("p1a_rvalid1", 32'(rvalid1), 32'd1);
    check("p1a_res", res, 32'hFF);
    a1 = 32'd10; b1 = 32'd4; aluc1 = 4'b0100;
    #1;
    check("p1b_gnt1", 32'(gnt1), 32'd1);
    tick();
    check("p1b_rvalid1", 32'(rvalid1), 32'd1);
    check("p1b_rvalid0", 32'(rvalid0), 32'd0);
    check("p1b_res", res, 32'd6);
    req1 = 1'b0;
    tick();
    check("p1_idle_rvalid1", 32'(rvalid1), 32'd0);

    // Contention: port 0 wins four cycles, then port 1 wins one; period 5.
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; aluc0 = 4'b0000;
    req1 = 1'b1; a1 = 32'd7; b1 = 32'd2; aluc1 = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("ct%0d_starve", k), 32'(starve), 32'(g1_pat[k]));
      check($sformatf("ct%0d_gnt1", k), 32'(gnt1), 32'(g1_pat[k]));
      check($sformatf("ct%0d_gnt0", k), 32'(gnt0), 32'(!g1_pat[k]));
      tick();
      check($sformatf("ct%0d_rvalid1", k), 32'(rvalid1), 32'(g1_pat[k]));
      check($sformatf("ct%0d_res", k), res, g1_pat[k] ? 32'd5 : 32'd2);
    end
`ifdef ALU_SHARE_ARB_STAT_EN
    check("ct_max_wait_seen", 32'(max_wait_seen), 32'd4);
    check("ct_cnt0", 32'(cnt0), 32'd9);
    check("ct_cnt1", 32'(cnt1), 32'd4);
`endif
    req1 = 1'b0;

    // Bit-difference opcode passes straight through.
    a0 = 32'hFFFF0000; b0 = 32'h0000FFFF; aluc0 = 4'b1110;
    tick();
    check("bd_rvalid0", 32'(rvalid0), 32'd1);
    check("bd_res", res, 32'h20);

    // Freeze in the result cycle: result and valid hold, no grants, aging holds.
    a0 = 32'd2; b0 = 32'd9; aluc0 = 4'b0000;
    #1;
    check("fz_acc_gnt0", 32'(gnt0), 32'd1);
    tick();
    freeze = 1'b1; req1 = 1'b1; a0 = 32'd100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("fz%0d_gnt0", k), 32'(gnt0), 32'd0);
      check($sformatf("fz%0d_gnt1", k), 32'(gnt1), 32'd0);
      check($sformatf("fz%0d_rvalid0", k), 32'(rvalid0), 32'd1);
      check($sformatf("fz%0d_res", k), res, 32'd11);
      tick();
    end
    check("fz_end_rvalid0", 32'(rvalid0), 32'd1);
    check("fz_end_starve", 32'(starve), 32'd0);
    freeze = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    check("fz_clear_rvalid0", 32'(rvalid0), 32'd0);
    check("fz_clear_res", res, 32'd11);

    // Reset right after a port 1 accept drops the result.
    req1 = 1'b1; a1 = 32'd3; b1 = 32'd4; aluc1 = 4'b0000;
    #1;
    check("rm_gnt1", 32'(gnt1), 32'd1);
    tick();
    check("rm_pre_rvalid1", 32'(rvalid1), 32'd1);
    check("rm_pre_res", res, 32'd7);
    req1 = 1'b0; reset = 1'b1;
    tick();
    check("rm_rvalid1", 32'(rvalid1), 32'd0);
    check("rm_res", res, 32'd0);
    check("rm_starve", 32'(starve), 32'd0);
`ifdef ALU_SHARE_ARB_STAT_EN
    check("rm_cnt0", 32'(cnt0), 32'd0);
    check("rm_cnt1", 32'(cnt1), 32'd0);
    check("rm_max_wait_seen", 32'(max_wait_seen), 32'd0);
`endif
    reset = 1'b0;

    // Reach starve, then reset: starve clears and port 1 is not granted during reset.
    req0 = 1'b1; req1 = 1'b1;
    tick(); tick(); tick(); tick();
    check("sr_starve_set", 32'(starve), 32'd1);
    reset = 1'b1;
    #1;
    check("sr_gnt1_in_reset", 32'(gnt1), 32'd0);
    tick();
    check("sr_starve_clr", 32'(starve), 32'd0);
    check("sr_rvalid0", 32'(rvalid0), 32'd0);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbiter/sequencer that shares one combinational 32-bit ALU (a, b, aluc -> s) between two requesters: port 0 = pipeline EX stage, port 1 = auxiliary engine (address-gen / debug unit).
- Fixed priority to port 0, with an aging counter that guarantees port 1 forward progress.
- Drives the shared ALU operand/opcode lines and registers the ALU result.
- Returns the registered result with a one-cycle-later valid strobe to the winning requester.

Parameters:
- MAX_WAIT, 4, consecutive denied cycles for port 1 before it overrides port 0 (legal 1..15).
- WAIT_W, 4, width of the aging counter; must hold MAX_WAIT.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  global stall; when 1, no grants are issued and all state holds.
- req0  in  1  port 0 request.
- a0  in  32  port 0 operand a.
- b0  in  32  port 0 operand b.
- aluc0  in  4  port 0 ALU opcode.
- gnt0  out  1  port 0 accepted this cycle (combinational).
- rvalid0  out  1  res holds port 0 result (registered pulse).
- req1, a1, b1, aluc1, gnt1, rvalid1  same as port 0, for port 1.
- alu_a  out  32  to shared ALU input a.
- alu_b  out  32  to shared ALU input b.
- alu_aluc  out  4  to shared ALU opcode.
- alu_s  in  32  from shared ALU result.
- res  out  32  registered result, shared by both ports.
- starve  out  1  aging counter has reached MAX_WAIT (registered).

Behaviour:
- Reset (synchronous, active-high): res=0, rvalid0=rvalid1=0, wait counter=0, starve=0, stat counters=0. gnt0/gnt1 are 0 while reset=1.
- Transfer: a request is accepted on a cycle where req_i && gnt_i.
  - Requester holds req_i, a_i, b_i, aluc_i stable until accepted.
  - Requester may present new operands in the cycle after acceptance, so back-to-back accepts are allowed every cycle.
- Grant logic (combinational, at most one grant per cycle; gnt0 && gnt1 is never 1):
  - freeze=1 or reset=1: gnt0=gnt1=0.
  - Only req0: gnt0=1. Only req1: gnt1=1.
  - Both requesting and starve=0: gnt0=1.
  - Both requesting and starve=1: gnt1=1.
- ALU drive:
  - alu_a/alu_b/alu_aluc = operands of the granted port.
  - With no grant, port 0's operands are driven (no glitch requirement; output is don't-care).
- Latency: exactly 1 cycle.
  - On the accepting edge: res <= alu_s, rvalid_i <= 1 for the winner, rvalid of the other port <= 0.
  - Cycle with no accept and freeze=0: rvalid0=rvalid1=0, res holds its last value.
  - freeze=1: res, rvalid0, rvalid1, counter and starve all hold. A pending rvalid stays high until the first unfrozen cycle, then clears unless a new accept occurs.
- Aging counter (WAIT_W bits), updated when freeze=0:
  - req1 && !gnt1: increment, saturating at MAX_WAIT.
  - gnt1 or !req1: clear to 0.
  - starve <= (next counter value == MAX_WAIT).
  - Effect: a continuously requesting port 1 waits at most MAX_WAIT cycles, then wins exactly one cycle.
- The block does not interpret aluc. It passes through any value, including multi-bit ops such as the bit-difference count (4'b1110) and shifts.
- Reset mid-transfer: an accepted op whose result is not yet visible is dropped (rvalid stays 0). Requesters must re-issue.

Optional Feature:
- Macro: ALU_SHARE_ARB_STAT_EN
- Defined:
  - Adds outputs cnt0 (out, 16) and cnt1 (out, 16) = number of accepted ops per port since reset.
  - Counters wrap 0xFFFF -> 0 and hold during freeze.
  - Adds output max_wait_seen (out, WAIT_W) = highest aging counter value observed since reset.
- Not defined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Port 0 only: req0=1, a0=5, b0=3, aluc0=4'b0000 -> gnt0=1 same cycle; next cycle rvalid0=1, res=8, rvalid1=0.
- Port 1 only, back-to-back:
  - cycle 0: a1=0xF0, b1=0x0F, aluc1=4'b0101 (OR); cycle 1: aluc1=4'b0100, a1=10, b1=4 (SUB).
  - -> cycle 1: res=0xFF, rvalid1=1; cycle 2: res=6, rvalid1=1.
- Contention/aging with MAX_WAIT=4: req0=req1=1 held continuously.
  - -> gnt0 for 4 cycles, starve=1, then gnt1 for exactly 1 cycle.
  - Counter then clears and the pattern repeats (period 5).
- Pass-through of the bit-difference opcode: port 0, a0=0xFFFF0000, b0=0x0000FFFF, aluc0=4'b1110 -> res=32 (0x20) one cycle later.
- Freeze: accept op, assert freeze in the result cycle for 3 cycles -> rvalid0 stays 1 and res stable; gnt0=gnt1=0 during freeze; rvalid0 clears on the first unfrozen idle cycle.
- Reset mid-op: accept port 1 op, assert reset on the next edge -> rvalid1=0, res=0, starve=0; with ALU_SHARE_ARB_STAT_EN, cnt0=cnt1=0.
